nukv_pred_sched: RTL and testbench

Scheduler in front of the predicate evaluation pipeline. Arbitrates between the normal (GET-path) predicate source and the scan predicate source, enforces that scans run only on an empty pipeline, and drives the pipeline's `scan_on_outside` qualifier. Tracks outstanding normal predicates so the per-stage predicate FIFOs (128 entries) are never overrun.

---
 rtl/nukv_pred_sched_pkg.sv | 18 +
 rtl/nukv_inflight_counter.sv | 55 +++++
 rtl/nukv_pred_sched.sv | 139 +++++++++++++
 tb/tb_nukv_pred_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nukv_pred_sched_pkg.sv
// Shared types and constants for the predicate scheduler.
// Optional statistics live behind NUKV_PRED_SCHED_STATS_EN in the top.
package nukv_pred_sched_pkg;

  localparam int PRED_FIFO_DEPTH = 128;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_DRAIN      = 2'd1,
    ST_SCAN_ISSUE = 2'd2,
    ST_SCAN_RUN   = 2'd3
  } sched_state_e;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/nukv_inflight_counter.sv
// Saturating in-flight counter with sticky underflow flag.
// Simultaneous inc/dec leaves the count unchanged.
module nukv_inflight_counter
  import nukv_pred_sched_pkg::*;
#(
  parameter int MAX = PRED_FIFO_DEPTH,
  parameter int W   = cnt_w(PRED_FIFO_DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         full_o,
  output logic         underflow_o
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] count_q, count_d;
  logic         uf_q, uf_d;

  always_comb begin
    count_d = count_q;
    uf_d    = uf_q;
    unique case (1'b1)
      inc_i & ~dec_i: begin
        if (count_q != MAXV)
          count_d = count_q + 1'b1;
      end
      dec_i & ~inc_i: begin
        if (count_q == '0)
          uf_d = 1'b1;
        else
          count_d = count_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      uf_q    <= uf_d;
    end
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == MAXV);
  assign underflow_o = uf_q;

endmodule

// File: rtl/nukv_pred_sched.sv
// Predicate scheduler: normal/scan arbitration, drain-before-scan.
// Define NUKV_PRED_SCHED_STATS_EN to add grant/drain statistics ports.
module nukv_pred_sched
  import nukv_pred_sched_pkg::*;
#(
  parameter int MEMORY_WIDTH    = 512,
  parameter int META_WIDTH      = 96,
  parameter int MAX_OUTSTANDING = PRED_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [META_WIDTH+MEMORY_WIDTH-1:0] norm_data,
  input  logic                               norm_valid,
  output logic                               norm_ready,
  input  logic [META_WIDTH+MEMORY_WIDTH-1:0] scan_data,
  input  logic                               scan_valid,
  output logic                               scan_ready,
  input  logic                               scan_done,
  output logic [META_WIDTH+MEMORY_WIDTH-1:0] pred_data,
  output logic                               pred_valid,
  output logic                               pred_scan,
  input  logic                               pred_ready,
  input  logic                               mon_valid,
  input  logic                               mon_ready,
  input  logic                               mon_last,
  output logic                               scan_on_outside,
  output logic [cnt_w(MAX_OUTSTANDING)-1:0]  outstanding,
  output logic                               error_underflow
`ifdef NUKV_PRED_SCHED_STATS_EN
  ,
  output logic [31:0]                        stat_norm_grants,
  output logic [31:0]                        stat_scan_grants,
  output logic [31:0]                        stat_drain_cycles
`endif
);

  localparam int CW = cnt_w(MAX_OUTSTANDING);

  sched_state_e state_q, state_d;
  logic         sos_q;
  logic         full;
  logic         norm_fire;
  logic         scan_fire;
  logic         cmpl;

  always_comb begin
    state_d    = state_q;
    pred_data  = norm_data;
    pred_scan  = 1'b0;
    pred_valid = 1'b0;
    norm_ready = 1'b0;
    scan_ready = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        pred_valid = norm_valid & ~scan_valid & ~full;
        norm_ready = pred_ready & ~scan_valid & ~full;
        if (scan_valid)
          state_d = (outstanding == '0) ? ST_SCAN_ISSUE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outstanding == '0)
          state_d = ST_SCAN_ISSUE;
      end
      ST_SCAN_ISSUE: begin
        pred_data  = scan_data;
        pred_scan  = 1'b1;
        pred_valid = scan_valid;
        scan_ready = pred_ready;
        if (scan_valid && pred_ready)
          state_d = ST_SCAN_RUN;
      end
      ST_SCAN_RUN: begin
        if (scan_done)
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      sos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sos_q   <= (state_d == ST_SCAN_ISSUE) || (state_d == ST_SCAN_RUN);
    end
  end

  assign scan_on_outside = sos_q;

  assign norm_fire = pred_valid & pred_ready & ~pred_scan;
  assign scan_fire = pred_valid & pred_ready & pred_scan;

  // Completions seen while a scan owns the pipeline belong to the scan.
  assign cmpl = mon_valid & mon_ready & mon_last &
                ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  nukv_inflight_counter #(
    .MAX (MAX_OUTSTANDING),
    .W   (CW)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (norm_fire),
    .dec_i       (cmpl),
    .count_o     (outstanding),
    .full_o      (full),
    .underflow_o (error_underflow)
  );

`ifdef NUKV_PRED_SCHED_STATS_EN
  logic [31:0] sng_q, ssg_q, sdc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sng_q <= '0;
      ssg_q <= '0;
      sdc_q <= '0;
    end else begin
      if (norm_fire)
        sng_q <= sng_q + 32'd1;
      if (scan_fire)
        ssg_q <= ssg_q + 32'd1;
      if (state_q == ST_DRAIN)
        sdc_q <= sdc_q + 32'd1;
    end
  end

  assign stat_norm_grants  = sng_q;
  assign stat_scan_grants  = ssg_q;
  assign stat_drain_cycles = sdc_q;
`else
  // Statistics disabled: scan fire only feeds the optional counters.
  logic unused_scan_fire;
  assign unused_scan_fire = scan_fire;
`endif

endmodule

// File: tb/tb_nukv_pred_sched.sv
// Directed self-checking bench for nukv_pred_sched.
// Inputs change on the falling edge; outputs sampled #1 later.
module tb_nukv_pred_sched;

  localparam int DW = 608;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] norm_data = '0;
  logic          norm_valid = 1'b0;
  logic          norm_ready;
  logic [DW-1:0] scan_data = '0;
  logic          scan_valid = 1'b0;
  logic          scan_ready;
  logic          scan_done = 1'b0;
  logic [DW-1:0] pred_data;
  logic          pred_valid;
  logic          pred_scan;
  logic          pred_ready = 1'b0;
  logic          mon_valid = 1'b0;
  logic          mon_ready = 1'b0;
  logic          mon_last = 1'b0;
  logic          scan_on_outside;
  logic [7:0]    outstanding;
  logic          error_underflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nukv_pred_sched dut (
    .clk             (clk),
    .rst             (rst),
    .norm_data       (norm_data),
    .norm_valid      (norm_valid),
    .norm_ready      (norm_ready),
    .scan_data       (scan_data),
    .scan_valid      (scan_valid),
    .scan_ready      (scan_ready),
    .scan_done       (scan_done),
    .pred_data       (pred_data),
    .pred_valid      (pred_valid),
    .pred_scan       (pred_scan),
    .pred_ready      (pred_ready),
    .mon_valid       (mon_valid),
    .mon_ready       (mon_ready),
    .mon_last        (mon_last),
    .scan_on_outside (scan_on_outside),
    .outstanding     (outstanding),
    .error_underflow (error_underflow)
  );

  task automatic cmpl(input logic on);
    mon_valid = on;
    mon_ready = on;
    mon_last  = on;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outstanding !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d exp=0", outstanding);
    end
    checks++;
    if (scan_on_outside !== 1'b0 || error_underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b exp=00", scan_on_outside, error_underflow);
    end
    checks++;
    if ({pred_valid, norm_ready, scan_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_hs got=%b exp=000", {pred_valid, norm_ready, scan_ready});
    end
    rst = 1'b0;
  endtask

  task automatic test_normal_burst;
    int fires = 0;
    pred_ready = 1'b1;
    norm_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      norm_data = DW'(i + 1);
      #1;
      if (pred_valid && norm_ready && !pred_scan && pred_data === norm_data)
        fires++;
      @(negedge clk);
    end
    norm_valid = 1'b0;
    #1;
    checks++;
    if (fires !== 10) begin
      failures++;
      $display("FAIL burst_fires got=%0d exp=10", fires);
    end
    checks++;
    if (outstanding !== 8'd10) begin
      failures++;
      $display("FAIL burst_cnt got=%0d exp=10", outstanding);
    end
  endtask

  task automatic test_full;
    norm_valid = 1'b1;
    repeat (118) @(negedge clk);
    #1;
    checks++;
    if (outstanding !== 8'd128 || norm_ready !== 1'b0 || pred_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_hold got cnt=%0d rdy=%b vld=%b exp 128/0/0",
               outstanding, norm_ready, pred_valid);
    end
    cmpl(1'b1);
    #1;
    checks++;
    if (norm_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_same_cycle got=%b exp=0", norm_ready);
    end
    @(negedge clk);
    cmpl(1'b0);
    #1;
    checks++;
    if (outstanding !== 8'd127 || norm_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_reopen got cnt=%0d rdy=%b exp 127/1", outstanding, norm_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (outstanding !== 8'd128 || norm_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_refill got cnt=%0d rdy=%b exp 128/0", outstanding, norm_ready);
    end
    norm_valid = 1'b0;
  endtask

  task automatic test_drain_scan;
    cmpl(1'b1);
    repeat (125) @(negedge clk);
    cmpl(1'b0);
    #1;
    checks++;
    if (outstanding !== 8'd3) begin
      failures++;
      $display("FAIL drain_pre got=%0d exp=3", outstanding);
    end
    scan_data  = {19{32'hC0FFEE01}};
    scan_valid = 1'b1;
    norm_valid = 1'b1;
    #1;
    checks++;
    if (norm_ready !== 1'b0 || pred_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_gate got rdy=%b vld=%b exp 0/0", norm_ready, pred_valid);
    end
    @(negedge clk);
    cmpl(1'b1);
    #1;
    checks++;
    if ({pred_valid, norm_ready, scan_ready} !== 3'b000) begin
      failures++;
      $display("FAIL drain_nogrant got=%b exp=000", {pred_valid, norm_ready, scan_ready});
    end
    repeat (3) @(negedge clk);
    cmpl(1'b0);
    #1;
    checks++;
    if (outstanding !== 8'd0 || pred_valid !== 1'b0 || scan_on_outside !== 1'b0) begin
      failures++;
      $display("FAIL drain_last got cnt=%0d vld=%b sos=%b exp 0/0/0",
               outstanding, pred_valid, scan_on_outside);
    end
    @(negedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_scan !== 1'b1 || scan_ready !== 1'b1 ||
        norm_ready !== 1'b0 || scan_on_outside !== 1'b1) begin
      failures++;
      $display("FAIL scan_issue got vld=%b scan=%b srdy=%b nrdy=%b sos=%b exp 1/1/1/0/1",
               pred_valid, pred_scan, scan_ready, norm_ready, scan_on_outside);
    end
    checks++;
    if (pred_data !== scan_data) begin
      failures++;
      $display("FAIL scan_data got=%h exp=%h", pred_data[31:0], scan_data[31:0]);
    end
    @(negedge clk);
    scan_valid = 1'b0;
    #1;
    checks++;
    if (scan_on_outside !== 1'b1 || pred_valid !== 1'b0) begin
      failures++;
      $display("FAIL scan_run_entry got sos=%b vld=%b exp 1/0", scan_on_outside, pred_valid);
    end
  endtask

  task automatic test_scan_run;
    cmpl(1'b1);
    repeat (5) @(negedge clk);
    cmpl(1'b0);
    #1;
    checks++;
    if (outstanding !== 8'd0 || error_underflow !== 1'b0 || pred_valid !== 1'b0) begin
      failures++;
      $display("FAIL scan_cmpl got cnt=%0d uf=%b vld=%b exp 0/0/0",
               outstanding, error_underflow, pred_valid);
    end
    scan_done = 1'b1;
    #1;
    checks++;
    if (scan_on_outside !== 1'b1) begin
      failures++;
      $display("FAIL scan_done_cycle got=%b exp=1", scan_on_outside);
    end
    @(negedge clk);
    scan_done = 1'b0;
    #1;
    checks++;
    if (scan_on_outside !== 1'b0 || pred_valid !== 1'b1 ||
        norm_ready !== 1'b1 || pred_scan !== 1'b0) begin
      failures++;
      $display("FAIL scan_exit got sos=%b vld=%b rdy=%b scan=%b exp 0/1/1/0",
               scan_on_outside, pred_valid, norm_ready, pred_scan);
    end
    @(negedge clk);
    norm_valid = 1'b0;
    #1;
    checks++;
    if (outstanding !== 8'd1) begin
      failures++;
      $display("FAIL resume_cnt got=%0d exp=1", outstanding);
    end
    cmpl(1'b1);
    @(negedge clk);
    cmpl(1'b0);
  endtask

  task automatic test_underflow;
    cmpl(1'b1);
    @(negedge clk);
    cmpl(1'b0);
    #1;
    checks++;
    if (error_underflow !== 1'b1 || outstanding !== 8'd0) begin
      failures++;
      $display("FAIL uflow_set got uf=%b cnt=%0d exp 1/0", error_underflow, outstanding);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (error_underflow !== 1'b1) begin
      failures++;
      $display("FAIL uflow_sticky got=%b exp=1", error_underflow);
    end
  endtask

  task automatic test_back_to_back;
    norm_valid = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (outstanding !== 8'd5) begin
      failures++;
      $display("FAIL b2b_cnt got=%0d exp=5", outstanding);
    end
    cmpl(1'b1);
    @(negedge clk);
    cmpl(1'b0);
    norm_valid = 1'b0;
    #1;
    checks++;
    if (outstanding !== 8'd5) begin
      failures++;
      $display("FAIL simul_cnt got=%0d exp=5", outstanding);
    end
  endtask

  task automatic test_scan_latency_reset;
    cmpl(1'b1);
    repeat (5) @(negedge clk);
    cmpl(1'b0);
    scan_done = 1'b1;
    @(negedge clk);
    scan_done = 1'b0;
    #1;
    checks++;
    if (scan_on_outside !== 1'b0 || outstanding !== 8'd0) begin
      failures++;
      $display("FAIL stray_done got sos=%b cnt=%0d exp 0/0", scan_on_outside, outstanding);
    end
    scan_data  = {19{32'h5CA11ED0}};
    scan_valid = 1'b1;
    #1;
    checks++;
    if (pred_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_c0 got=%b exp=0", pred_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_scan !== 1'b1) begin
      failures++;
      $display("FAIL lat_c1 got vld=%b scan=%b exp 1/1", pred_valid, pred_scan);
    end
    @(negedge clk);
    scan_valid = 1'b0;
    #1;
    checks++;
    if (scan_on_outside !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst_sos got=%b exp=1", scan_on_outside);
    end
    rst = 1'b1;
    norm_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (outstanding !== 8'd0 || scan_on_outside !== 1'b0 ||
        error_underflow !== 1'b0 || scan_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_scan got cnt=%0d sos=%b uf=%b srdy=%b exp 0/0/0/0",
               outstanding, scan_on_outside, error_underflow, scan_ready);
    end
    checks++;
    if (pred_valid !== 1'b1 || pred_scan !== 1'b0) begin
      failures++;
      $display("FAIL rst_run got vld=%b scan=%b exp 1/0", pred_valid, pred_scan);
    end
    norm_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_burst();
    test_full();
    test_drain_scan();
    test_scan_run();
    test_underflow();
    test_back_to_back();
    test_scan_latency_reset();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
